// File: rtl/gate_bist_pkg.sv
// Shared types and sizes for the 2-input gate BIST controller.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } bist_state_e;

   localparam int NUM_VECTORS = 4;
   localparam int IDX_W       = 2;
   localparam int ERR_W       = 3;
   localparam int SETTLE_W    = 4;

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Control, result and GUT-facing signals of the gate BIST controller.
interface gate_bist_ctrl_if;
   import gate_bist_pkg::*;

   logic                   start;
   logic                   abort;
   logic [NUM_VECTORS-1:0] expected_tt;
   logic                   gate_a;
   logic                   gate_b;
   logic                   gate_out;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic [ERR_W-1:0]       err_count;
   logic                   fail_valid;
   logic [IDX_W-1:0]       first_fail_idx;

   // master drives the controller and hosts the GUT; slave is the controller
   modport master (
      output start, abort, expected_tt, gate_out,
      input  gate_a, gate_b, busy, done, pass, err_count, fail_valid, first_fail_idx
   );

   modport slave (
      input  start, abort, expected_tt, gate_out,
      output gate_a, gate_b, busy, done, pass, err_count, fail_valid, first_fail_idx
   );

endinterface

// File: rtl/gate_bist_settle_timer.sv
// Loadable down-counter that stops at zero; zero_o flags expiry.
module gate_bist_settle_timer
   import gate_bist_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic [SETTLE_W-1:0] load_val_i,
   input  logic                dec_i,
   output logic                zero_o
);

   logic [SETTLE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - SETTLE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Sweeps all four input vectors of a 2-input GUT, compares against a latched truth table.
module gate_bist_ctrl
   import gate_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   gate_bist_ctrl_if.slave  bus
);

   localparam logic [SETTLE_W-1:0] RELOAD   = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   bist_state_e            state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_VECTORS-1:0] tt_q, tt_d;
   logic [ERR_W-1:0]       err_q, err_d;
   logic                   fv_q, fv_d;
   logic [IDX_W-1:0]       ffi_q, ffi_d;
   logic                   tmr_load, tmr_dec, tmr_zero;
   logic                   mismatch;

   gate_bist_settle_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (RELOAD),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   assign mismatch = (bus.gate_out != tt_q[idx_q]);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tt_d     = tt_q;
      err_d    = err_q;
      fv_d     = fv_q;
      ffi_d    = ffi_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // abort is meaningless outside a sweep, so start alone decides
            if (bus.start) begin
               state_d  = ST_SETTLE;
               idx_d    = '0;
               tt_d     = bus.expected_tt;
               err_d    = '0;
               fv_d     = 1'b0;
               ffi_d    = '0;
               tmr_load = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               ffi_d   = '0;
            end else if (tmr_zero) begin
               state_d = ST_CHECK;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_CHECK: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               ffi_d   = '0;
            end else begin
               if (mismatch) begin
                  err_d = err_q + ERR_W'(1);
                  if (!fv_q) begin
                     fv_d  = 1'b1;
                     ffi_d = idx_q;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_SETTLE;
                  idx_d    = idx_q + IDX_W'(1);
                  tmr_load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         tt_q    <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         ffi_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tt_q    <= tt_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         ffi_q   <= ffi_d;
      end
   end

   // GUT inputs come straight from the index register, so they hold for SETTLE+CHECK
   assign bus.gate_a         = idx_q[1];
   assign bus.gate_b         = idx_q[0];
   assign bus.busy           = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign bus.done           = (state_q == ST_DONE);
   assign bus.pass           = (state_q == ST_DONE) && (err_q == '0);
   assign bus.err_count      = err_q;
   assign bus.fail_valid     = fv_q;
   assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized and directed checks of gate_bist_ctrl against a truth-table reference model.
module tb_gate_bist_ctrl;

   localparam int S = 2;
   localparam int SWEEP = 4 * (S + 1);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] gut_tt = 4'b1110;
   int         checks = 0;
   int         errors = 0;

   gate_bist_ctrl_if bus ();

   gate_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural GUT: output is the entry of its own truth table at {a,b}
   assign bus.gate_out = gut_tt[{bus.gate_a, bus.gate_b}];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Results visible n edges after the accepting edge (edge 1): vector v's compare lands at (v+1)(S+1)+1
   task automatic model(input logic [3:0] exp_tt, input logic [3:0] g, input int n,
                        output int e, output bit fv, output int ffi);
      e = 0; fv = 0; ffi = 0;
      for (int v = 0; v < 4; v++) begin
         if (((v + 1) * (S + 1) + 1 <= n) && (g[v] != exp_tt[v])) begin
            if (!fv) ffi = v;
            fv = 1;
            e++;
         end
      end
   endtask

   task automatic check_results(input string tag, input logic [3:0] exp_tt, input int n);
      int e, ffi; bit fv;
      model(exp_tt, gut_tt, n, e, fv, ffi);
      chk({tag, "_err"}, 32'(bus.err_count), 32'(e));
      chk({tag, "_fv"}, 32'(bus.fail_valid), 32'(fv));
      if (fv) chk({tag, "_ffi"}, 32'(bus.first_fail_idx), 32'(ffi));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ab"}, 32'({bus.gate_a, bus.gate_b}), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
      chk({tag, "_err"}, 32'(bus.err_count), 32'd0);
      chk({tag, "_fv"}, 32'(bus.fail_valid), 32'd0);
      chk({tag, "_ffi"}, 32'(bus.first_fail_idx), 32'd0);
   endtask

   // Full sweep; caller leaves the DUT in IDLE or DONE. Returns at edge 1+4(S+1), in DONE.
   task automatic sweep(input string tag, input logic [3:0] exp_tt, input logic [3:0] g,
                        input bit noisy);
      int e, ffi; bit fv;
      gut_tt          = g;
      bus.expected_tt = exp_tt;
      bus.start       = 1'b1;
      bus.abort       = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int n = 1; n <= SWEEP; n++) begin
         bus.expected_tt = 4'($urandom);
         chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
         chk({tag, "_done"}, 32'(bus.done), 32'd0);
         chk({tag, "_vec"}, 32'({bus.gate_a, bus.gate_b}), 32'((n - 1) / (S + 1)));
         check_results(tag, exp_tt, n);
         bus.start = (noisy && n < SWEEP) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      model(exp_tt, g, SWEEP + 1, e, fv, ffi);
      chk({tag, "_end_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_end_pass"}, 32'(bus.pass), 32'(e == 0));
      check_results({tag, "_end"}, exp_tt, SWEEP + 1);
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.expected_tt = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      sweep("or_pass", 4'b1110, 4'b1110, 1'b0);
      // back-to-back: start straight from DONE, results must clear at once
      sweep("and_tt", 4'b1000, 4'b1110, 1'b0);
      sweep("b2b_or", 4'b1110, 4'b1110, 1'b0);
      sweep("stuck0", 4'b1110, 4'b0000, 1'b0);
      sweep("busy_start", 4'b1110, 4'b1110, 1'b1);

      // abort during SETTLE of vector 2 (edges 7..8)
      gut_tt = 4'b0000;
      bus.expected_tt = 4'b1110;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_pre_vec", 32'({bus.gate_a, bus.gate_b}), 32'd2);
      chk("abort_pre_err", 32'(bus.err_count), 32'd1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check_reset("abort");
      @(posedge clk); #1;
      check_reset("abort_hold");
      sweep("after_abort", 4'b1110, 4'b1110, 1'b0);

      // reset during CHECK of vector 1 (edge 6), with a mismatch pending
      sweep("pre_rst", 4'b0110, 4'b0110, 1'b0);
      gut_tt = 4'b0000;
      bus.expected_tt = 4'b1110;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_pre_vec", 32'({bus.gate_a, bus.gate_b}), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset("mid_rst");

      for (int k = 0; k < 6; k++)
         sweep("rand", 4'($urandom), 4'($urandom), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test controller for a single 2-input gate under test (GUT) built from the project's NAND primitives. It sweeps all four input combinations, waits a programmable settle time, samples the GUT output, and compares it against a caller-supplied truth table. It reports pass/fail, an error count and the first failing vector. It sits beside the gate library and turns the per-gate checks now done in simulation benches into synthesizable on-FPGA checks.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range is 1..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: begin a sweep. Sampled only in IDLE or DONE.
- `abort` in 1: cancel a sweep in progress.
- `expected_tt` in 4: expected GUT output. Bit i is the expected result for `{a,b}` = i. Latched when `start` is accepted.
- `gate_a` out 1: GUT input a, equal to vector index bit 1.
- `gate_b` out 1: GUT input b, equal to vector index bit 0.
- `gate_out` in 1: GUT output (combinational from `gate_a`/`gate_b`).
- `busy` out 1: high in SETTLE or CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: `done` && `err_count`==0.
- `err_count` out 3: number of mismatches, 0..4.
- `fail_valid` out 1: at least one mismatch has occurred this sweep.
- `first_fail_idx` out 2: vector index of the first mismatch. Valid only when `fail_valid`.

## Operation
- States:
  - IDLE
  - SETTLE: hold the current vector; settle counter counts down.
  - CHECK: one cycle; sample and compare.
  - DONE
- Transitions:
  - IDLE/DONE → SETTLE on `start`. Vector index is 0, `expected_tt` is latched, the settle counter is loaded with `SETTLE_CYCLES`-1, and `err_count`, `fail_valid` and `first_fail_idx` are cleared.
  - SETTLE → CHECK when the settle counter reaches 0. Otherwise decrement.
  - CHECK → SETTLE with index+1 and the counter reloaded, when index<3.
  - CHECK → DONE when index==3.
  - DONE holds until `start`, which re-arms directly. There is no pass through IDLE.
- Compare in CHECK: mismatch = `gate_out` != latched_tt[index]. On mismatch:
  - `err_count` increments.
  - If `fail_valid` was 0: set `fail_valid` and capture `first_fail_idx` = index.
- `gate_a`/`gate_b` are registered from the index and stay stable for the whole SETTLE+CHECK window of each vector.
- Abort: `abort` in SETTLE or CHECK → IDLE next cycle.
  - Results are cleared, `done` stays 0, and GUT inputs return to 00.
  - `abort` in IDLE or DONE is ignored.
- Simultaneous events:
  - `start`&&`abort` in IDLE/DONE: `start` is accepted (abort has no effect outside a sweep).
  - `start` while busy is ignored.
  - `expected_tt` changes after acceptance are ignored.
- Reset is synchronous and wins over everything, including mid-sweep. The block returns to IDLE.
- Reset values of outputs: `gate_a`=0, `gate_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail_idx`=0.

## Timing
- `start` sampled at edge 0 gives:
  - vector v driven from edge 1+v·(S+1), where S=`SETTLE_CYCLES`;
  - CHECK for vector v at edge (v+1)(S+1);
  - `done` high from edge 1+4(S+1).
- With S=2, `done` rises 13 cycles after `start`.
- `err_count`, `fail_valid` and `first_fail_idx` update the cycle after the CHECK in which the mismatch occurred. All three are final when `done` rises.
- `pass` is combinational from registered state. There are no combinational paths from inputs to outputs.
- `gate_out` is sampled only in CHECK. There are at least S cycles between an input change and its sample.

## Structure
- Package `gate_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - `NUM_VECTORS`=4, `IDX_W`=2, `ERR_W`=3, `SETTLE_W`=4.
- Single module with no mandatory sub-modules. The GUT is instantiated outside, in a wrapper or testbench.
- Optional sub-module: `gate_bist_settle_timer` (loadable down-counter with zero flag).

## Test plan
- OR gate, `expected_tt`=4'b1110, S=2, `start` pulse:
  - `gate_a`/`gate_b` go 00, 01, 10, 11;
  - `done` at cycle 13, `pass`=1, `err_count`=0, `fail_valid`=0.
- Same GUT with `expected_tt`=4'b1000 (AND table):
  - mismatches on indices 1 and 2;
  - `err_count`=2, `fail_valid`=1, `first_fail_idx`=1, `pass`=0.
- Stuck-at-0 GUT model, `expected_tt`=4'b1110: `err_count`=3, `first_fail_idx`=1.
- `abort` asserted in the SETTLE of vector 2:
  - IDLE next cycle with `busy`=0, `done`=0, `err_count`=0, GUT inputs 00;
  - a later `start` runs a clean 13-cycle sweep.
- `rst` asserted in the CHECK of vector 1: all outputs take their reset values the next cycle.
- Back-to-back: `start` in DONE re-arms immediately, with results cleared the next cycle.
- `start` pulses while busy are ignored; the sweep still completes at cycle 13.
